blocking_channel_peer: RTL and testbench
========================================

Name: blocking_channel_peer

Overview:
Environment-side peer for generated modules with blocking-port interfaces. It is the writer for a module's blocking input port and the reader for its blocking output port. Local request words are buffered in a FIFO and offered on the module's input port. Words taken from the module's output port are buffered in a second FIFO for local consumption. Used in testbenches and integration shells around generated blocks.

Parameters:
DATA_W, 32, width of the flattened payload word on both channels
DEPTH, 4, entries per FIFO (power of 2, >=2)
MAX_OUT, 2, max words sent to the module and not yet answered (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
push_valid  in  1  local request word valid
push_data  in  DATA_W  local request word
push_ready  out  1  request FIFO not full
pop_valid  out  1  response FIFO not empty
pop_data  out  DATA_W  response FIFO head
pop_ready  in  1  local consumer takes head
mod_in_data  out  DATA_W  payload to module blocking input
mod_in_sync  out  1  payload offered (peer side of the input handshake)
mod_in_notify  in  1  module ready to read its input
mod_out_data  in  DATA_W  payload from module blocking output
mod_out_sync  out  1  peer ready to take output
mod_out_notify  in  1  module offering output
outstanding  out  8  sent minus received, saturating
tx_count  out  16  words sent, wraps
rx_count  out  16  words received, wraps
err_unexpected  out  1  sticky: word received while outstanding==0

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. On reset, both FIFOs are emptied, all counters are 0, and err_unexpected=0. Resulting outputs: push_ready=1, pop_valid=0, mod_in_sync=0, mod_out_sync=1, mod_in_data=0, pop_data=0.
- Reset mid-transfer: any in-flight words are discarded and no partial state is retained.
- Local push: a word is accepted when push_valid && push_ready. push_ready = !req_full.
- Local pop: the head is removed when pop_valid && pop_ready.
- FIFOs have no bypass. A word pushed into an empty FIFO becomes visible on the next cycle, so minimum latency from push to mod_in_sync is 1 cycle.
- Send handshake:
  - mod_in_sync = !req_empty && (outstanding < MAX_OUT).
  - mod_in_data = request FIFO head.
  - A transfer occurs in a cycle where mod_in_sync && mod_in_notify. On transfer, the head is popped and tx_count increments.
  - While mod_in_sync=1 and no transfer has occurred, mod_in_data must hold stable.
- Receive handshake:
  - mod_out_sync = !rsp_full.
  - A transfer occurs in a cycle where mod_out_sync && mod_out_notify. On transfer, mod_out_data is written to the response FIFO and rx_count increments.
- No combinational paths: mod_in_sync and mod_out_sync depend only on registered state, never on notify inputs.
- outstanding counter:
  - +1 on a send, -1 on a receive.
  - Send and receive in the same cycle: unchanged.
  - Receive while outstanding==0: stays 0 and err_unexpected sets. err_unexpected clears only on rst. The word is still stored.
- Full/empty boundaries:
  - Request FIFO full: push_ready=0 and the push is ignored.
  - Response FIFO full: mod_out_sync=0 and the module stalls.
  - Simultaneous push and send on the same FIFO: occupancy unchanged.
  - Simultaneous receive and pop on the same FIFO: occupancy unchanged.
- Counters: tx_count and rx_count wrap 0xFFFF -> 0x0000.

Test Plan:
- Push 0xA5 with mod_in_notify=1 -> mod_in_sync rises the next cycle with mod_in_data=0xA5. Transfer occurs that cycle; tx_count=1, outstanding=1.
- MAX_OUT=2, push 3 words, mod_in_notify=1, mod_out_notify=0 -> exactly 2 sends, then mod_in_sync=0 with word 3 held. One module output (0x11) -> third send next cycle, and pop_data=0x11.
- Push 3 words (0x01, 0x02, 0x03) with mod_in_notify low for 5 cycles -> mod_in_sync=1 with mod_in_data=0x01 stable throughout. Raise mod_in_notify -> sends complete in order 0x01, 0x02, 0x03.
- pop_ready=0, module offers 5 words with DEPTH=4 -> 4 accepted, then mod_out_sync=0. A single pop -> fifth word accepted; pop order matches arrival order.
- Module offers a word with outstanding=0 -> err_unexpected=1, outstanding stays 0, word poppable. Further traffic does not clear the flag; rst does.
- Assert rst during a stalled send with both FIFOs non-empty -> all outputs return to reset values; no stale word appears afterwards.

Source files
------------

// File: rtl/blocking_channel_peer.sv
// Environment-side peer for a generated block with blocking ports.
// Local request words queue in req_mem and are offered on mod_in_*;
// words taken from mod_out_* queue in rsp_mem for local consumption.
// Both FIFOs have no bypass, and both sync outputs come from registered state only.
module blocking_channel_peer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] mod_in_data,
  output logic              mod_in_sync,
  input  logic              mod_in_notify,
  input  logic [DATA_W-1:0] mod_out_data,
  output logic              mod_out_sync,
  input  logic              mod_out_notify,
  output logic [7:0]        outstanding,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output logic              err_unexpected
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] req_mem [DEPTH];
  logic [DATA_W-1:0] rsp_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] req_wr, req_rd, rsp_wr, rsp_rd;
  logic req_empty, req_full, rsp_empty, rsp_full;
  logic push_fire, send_fire, recv_fire, pop_fire;

  assign req_empty = (req_wr == req_rd);
  assign req_full  = (req_wr[AW] != req_rd[AW]) && (req_wr[AW-1:0] == req_rd[AW-1:0]);
  assign rsp_empty = (rsp_wr == rsp_rd);
  assign rsp_full  = (rsp_wr[AW] != rsp_rd[AW]) && (rsp_wr[AW-1:0] == rsp_rd[AW-1:0]);

  assign push_ready   = !req_full;
  assign pop_valid    = !rsp_empty;
  assign mod_in_sync  = !req_empty && (outstanding < 8'(MAX_OUT));
  assign mod_out_sync = !rsp_full;

  // Heads read as zero when empty, so words left in storage from before a reset never show.
  assign mod_in_data = req_empty ? '0 : req_mem[req_rd[AW-1:0]];
  assign pop_data    = rsp_empty ? '0 : rsp_mem[rsp_rd[AW-1:0]];

  assign push_fire = push_valid && push_ready;
  assign send_fire = mod_in_sync && mod_in_notify;
  assign recv_fire = mod_out_sync && mod_out_notify;
  assign pop_fire  = pop_valid && pop_ready;

  // FIFO storage writes; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_fire) req_mem[req_wr[AW-1:0]] <= push_data;
    if (recv_fire) rsp_mem[rsp_wr[AW-1:0]] <= mod_out_data;
  end

  // FIFO pointer updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr <= '0;
      req_rd <= '0;
      rsp_wr <= '0;
      rsp_rd <= '0;
    end else begin
      if (push_fire) req_wr <= req_wr + 1'b1;
      if (send_fire) req_rd <= req_rd + 1'b1;
      if (recv_fire) rsp_wr <= rsp_wr + 1'b1;
      if (pop_fire)  rsp_rd <= rsp_rd + 1'b1;
    end
  end

  // Transfer counters; the 16-bit counts wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (send_fire) tx_count <= tx_count + 16'd1;
      if (recv_fire) rx_count <= rx_count + 16'd1;
    end
  end

  // Outstanding tracking: a lone receive at zero is unexpected and latches the error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      case ({send_fire, recv_fire})
        2'b10: if (outstanding != 8'hFF) outstanding <= outstanding + 8'd1;
        2'b01: begin
          if (outstanding == 8'd0) err_unexpected <= 1'b1;
          else                     outstanding    <= outstanding - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blocking_channel_peer.sv
// Directed bench for blocking_channel_peer: one vector table plus short hand-written sequences.
module tb_blocking_channel_peer;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, pop_ready, mod_in_notify, mod_out_notify;
  logic [31:0] push_data, mod_out_data;
  logic        push_ready, pop_valid, mod_in_sync, mod_out_sync, err_unexpected;
  logic [31:0] pop_data, mod_in_data;
  logic [7:0]  outstanding;
  logic [15:0] tx_count, rx_count;

  int tests = 0;
  int fails = 0;

  blocking_channel_peer #(.DATA_W(32), .DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .mod_in_data(mod_in_data), .mod_in_sync(mod_in_sync), .mod_in_notify(mod_in_notify),
    .mod_out_data(mod_out_data), .mod_out_sync(mod_out_sync), .mod_out_notify(mod_out_notify),
    .outstanding(outstanding), .tx_count(tx_count), .rx_count(rx_count),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic        pr;
    logic        in_n;
    logic        on;
    logic [31:0] od;
    logic        e_sync;
    logic [31:0] e_data;
    logic [7:0]  e_out;
    logic [15:0] e_tx;
    logic        e_pv;
    logic [31:0] e_pd;
    logic [15:0] e_rx;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pd, input logic pr,
                       input logic in_n, input logic on, input logic [31:0] od);
    push_valid = pv; push_data = pd; pop_ready = pr;
    mod_in_notify = in_n; mod_out_notify = on; mod_out_data = od;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " push_ready"}, 32'(push_ready), 32'd1);
    chk({tag, " pop_valid"}, 32'(pop_valid), 32'd0);
    chk({tag, " mod_in_sync"}, 32'(mod_in_sync), 32'd0);
    chk({tag, " mod_out_sync"}, 32'(mod_out_sync), 32'd1);
    chk({tag, " mod_in_data"}, mod_in_data, 32'd0);
    chk({tag, " pop_data"}, pop_data, 32'd0);
    chk({tag, " outstanding"}, 32'(outstanding), 32'd0);
    chk({tag, " tx_count"}, 32'(tx_count), 32'd0);
    chk({tag, " rx_count"}, 32'(rx_count), 32'd0);
    chk({tag, " err"}, 32'(err_unexpected), 32'd0);
  endtask

  initial begin
    // pv pd pr in_n on od | sync data out tx pv pd rx  (expected before this cycle's edge)
    vecs[0]  = '{1, 32'hA5, 0, 1, 0, 0,     0, 32'h00, 0, 0, 0, 32'h00, 0};
    vecs[1]  = '{0, 0,      0, 1, 0, 0,     1, 32'hA5, 0, 0, 0, 32'h00, 0};
    vecs[2]  = '{0, 0,      0, 0, 1, 32'hB0, 0, 32'h00, 1, 1, 0, 32'h00, 0};
    vecs[3]  = '{0, 0,      1, 0, 0, 0,     0, 32'h00, 0, 1, 1, 32'hB0, 1};
    vecs[4]  = '{1, 32'h01, 0, 1, 0, 0,     0, 32'h00, 0, 1, 0, 32'h00, 1};
    vecs[5]  = '{1, 32'h02, 0, 1, 0, 0,     1, 32'h01, 0, 1, 0, 32'h00, 1};
    vecs[6]  = '{1, 32'h03, 0, 1, 0, 0,     1, 32'h02, 1, 2, 0, 32'h00, 1};
    vecs[7]  = '{0, 0,      0, 1, 0, 0,     0, 32'h03, 2, 3, 0, 32'h00, 1};
    vecs[8]  = '{0, 0,      0, 1, 1, 32'h11, 0, 32'h03, 2, 3, 0, 32'h00, 1};
    vecs[9]  = '{0, 0,      0, 1, 0, 0,     1, 32'h03, 1, 3, 1, 32'h11, 2};
    vecs[10] = '{0, 0,      1, 0, 0, 0,     0, 32'h00, 2, 4, 1, 32'h11, 2};
    vecs[11] = '{0, 0,      0, 0, 0, 0,     0, 32'h00, 2, 4, 0, 32'h00, 2};

    do_reset();
    chk_reset_outputs("reset");

    // Table: first-word latency, MAX_OUT throttling, response unblocking the held word.
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d mod_in_sync", i), 32'(mod_in_sync), 32'(vecs[i].e_sync));
      chk($sformatf("v%0d mod_in_data", i), mod_in_data, vecs[i].e_data);
      chk($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
      chk($sformatf("v%0d tx_count", i), 32'(tx_count), 32'(vecs[i].e_tx));
      chk($sformatf("v%0d pop_valid", i), 32'(pop_valid), 32'(vecs[i].e_pv));
      chk($sformatf("v%0d pop_data", i), pop_data, vecs[i].e_pd);
      chk($sformatf("v%0d rx_count", i), 32'(rx_count), 32'(vecs[i].e_rx));
      drive(vecs[i].pv, vecs[i].pd, vecs[i].pr, vecs[i].in_n, vecs[i].on, vecs[i].od);
      step();
    end
    chk("table err", 32'(err_unexpected), 32'd0);

    // Held word stays stable while the module is not ready, then drains in order.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'(k + 1), 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d sync", k), 32'(mod_in_sync), 32'd1);
      chk($sformatf("hold%0d data", k), mod_in_data, 32'h01);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d sync", k), 32'(mod_in_sync), 32'd1);
      chk($sformatf("drain%0d data", k), mod_in_data, 32'(k + 1));
      drive(0, 0, 0, 1, (k > 0), 32'hE0 + 32'(k));
      step();
    end
    drive(0, 0, 0, 0, 1, 32'hE3);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("drain tx_count", 32'(tx_count), 32'd3);
    chk("drain outstanding", 32'(outstanding), 32'd0);
    chk("drain err", 32'(err_unexpected), 32'd0);

    // Response FIFO fills at DEPTH, stalls the module, one pop admits the fifth word.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d mod_out_sync", k), 32'(mod_out_sync), 32'd1);
      drive(0, 0, 0, 0, 1, 32'h21 + 32'(k));
      step();
    end
    chk("full mod_out_sync", 32'(mod_out_sync), 32'd0);
    chk("full rx_count", 32'(rx_count), 32'd4);
    drive(0, 0, 1, 0, 1, 32'h25);
    step();
    chk("after pop mod_out_sync", 32'(mod_out_sync), 32'd1);
    drive(0, 0, 0, 0, 1, 32'h25);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order%0d pop_valid", k), 32'(pop_valid), 32'd1);
      chk($sformatf("order%0d pop_data", k), pop_data, 32'h22 + 32'(k));
      drive(0, 0, 1, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("order empty", 32'(pop_valid), 32'd0);
    chk("order rx_count", 32'(rx_count), 32'd5);
    chk("order err", 32'(err_unexpected), 32'd1);

    // Unexpected word: flag sets, outstanding stays 0, word kept; flag sticky until reset.
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h77);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("unexp err", 32'(err_unexpected), 32'd1);
    chk("unexp outstanding", 32'(outstanding), 32'd0);
    chk("unexp pop_valid", 32'(pop_valid), 32'd1);
    chk("unexp pop_data", pop_data, 32'h77);
    drive(1, 32'hAB, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk("unexp send outstanding", 32'(outstanding), 32'd1);
    drive(0, 0, 0, 0, 1, 32'h88);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("sticky err", 32'(err_unexpected), 32'd1);
    chk("sticky outstanding", 32'(outstanding), 32'd0);
    chk("sticky rx_count", 32'(rx_count), 32'd2);
    do_reset();
    chk("err cleared", 32'(err_unexpected), 32'd0);

    // Asynchronous reset during a stalled send with both FIFOs holding data.
    drive(1, 32'hC1, 0, 0, 0, 0);
    step();
    drive(1, 32'hC2, 0, 0, 1, 32'hD1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre-rst mod_in_sync", 32'(mod_in_sync), 32'd1);
    chk("pre-rst pop_valid", 32'(pop_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post-rst%0d sync", k), 32'(mod_in_sync), 32'd0);
      chk($sformatf("post-rst%0d in_data", k), mod_in_data, 32'd0);
      chk($sformatf("post-rst%0d pop_valid", k), 32'(pop_valid), 32'd0);
      chk($sformatf("post-rst%0d pop_data", k), pop_data, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
